// File: rtl/mem_arbiter_if.sv
// Shared data-RAM arbitration bus: CPU memory-stage port, audio burst port and RAM port.
interface mem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;
  logic        cpu_stall;

  logic        aud_req;
  logic [31:0] aud_base;
  logic [3:0]  aud_len;
  logic        aud_ack;
  logic [31:0] aud_rdata;
  logic        aud_valid;
  logic        aud_done;
  logic        aud_busy;

  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  aud_req, aud_base, aud_len,
    input  mem_rdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    output aud_ack, aud_rdata, aud_valid, aud_done, aud_busy,
    output mem_we, mem_addr, mem_wdata
  );

  // Requester / RAM side.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output aud_req, aud_base, aud_len,
    output mem_rdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    input  aud_ack, aud_rdata, aud_valid, aud_done, aud_busy,
    input  mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shared data-RAM arbiter: CPU has zero-latency access in IDLE; audio bursts take the RAM
// in AUD, with a bounded wait counter so the CPU cannot starve the audio engine.
module mem_arbiter #(
  parameter int unsigned AUD_MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam logic [3:0] MaxWait = 4'(AUD_MAX_WAIT);

  typedef enum logic {IDLE, AUD} state_t;

  state_t      state, nextState;
  logic [3:0]  waitCnt;
  logic [3:0]  remaining;
  logic [31:0] burstAddr;
  logic [31:0] audRdata;
  logic        audAck, audValid, audDone;
  logic        acceptBurst;
  logic        cpuAck;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState     = state;
    acceptBurst   = 1'b0;
    cpuAck        = 1'b0;
    bus.cpu_rdata = '0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (state)
      IDLE: begin
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        bus.mem_we    = bus.cpu_req & bus.cpu_we;
        cpuAck        = bus.cpu_req;
        bus.cpu_rdata = bus.mem_rdata;
        // The CPU access of the accepting cycle still completes; the burst starts next cycle.
        if (bus.aud_req && (!bus.cpu_req || waitCnt == MaxWait)) begin
          acceptBurst = 1'b1;
          nextState   = AUD;
        end
      end
      AUD: begin
        bus.mem_addr = burstAddr;
        if (remaining <= 4'd1) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      waitCnt   <= '0;
      remaining <= '0;
      burstAddr <= '0;
      audRdata  <= '0;
      audAck    <= 1'b0;
      audValid  <= 1'b0;
      audDone   <= 1'b0;
    end else begin
      audAck   <= acceptBurst;
      audValid <= (state == AUD);
      audDone  <= (state == AUD) && (remaining <= 4'd1);
      if (state == AUD) begin
        audRdata  <= bus.mem_rdata;
        burstAddr <= burstAddr + 32'd1;
        remaining <= remaining - 4'd1;
      end else if (acceptBurst) begin
        burstAddr <= bus.aud_base;
        remaining <= (bus.aud_len == 4'd0) ? 4'd1 : bus.aud_len;
        waitCnt   <= '0;
      end else if (bus.aud_req && bus.cpu_req && waitCnt != MaxWait) begin
        waitCnt <= waitCnt + 4'd1;
      end
    end
  end

  assign bus.cpu_ack   = cpuAck;
  assign bus.cpu_stall = bus.cpu_req & ~cpuAck;
  assign bus.aud_ack   = audAck;
  assign bus.aud_rdata = audRdata;
  assign bus.aud_valid = audValid;
  assign bus.aud_done  = audDone;
  assign bus.aud_busy  = (state == AUD);

endmodule
